conf_int_add__acc_sel_ctrl: RTL and testbench
=============================================

# conf_int_add__acc_sel_ctrl

Precision controller that drives the `acc__sel` input of the 24-bit configurable integer adder wrapper, the other end of that select interface. It accepts an operand stream, registers operands and the select onto the adder ports, and captures the 25-bit sum. While in approximate mode it periodically probes the approximate error by re-running one operand pair in accurate mode. It falls back to accurate mode for a fixed number of operations whenever the error exceeds a threshold.

## Interface
- DATA_PATH_BITWIDTH, 24, operand width.
- PROBE_PERIOD, 64, accepted approximate-mode ops per probe; minimum 2.
- ERR_THRESH, 256, absolute error above which accurate fallback is taken.
- ACC_HOLD, 32, accepted ops spent in accurate mode per fallback; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when `in_valid & in_ready`.
- a_in, b_in  in  DATA_PATH_BITWIDTH  operands.
- force_acc  in  1  level input that forces accurate mode and suppresses probes.
- a, b  out  DATA_PATH_BITWIDTH  registered operands to the adder.
- acc__sel  out  1  registered select to the adder; 1 selects accurate, 0 selects approximate.
- d  in  DATA_PATH_BITWIDTH+1  combinational sum returned from the adder.
- d_out  out  DATA_PATH_BITWIDTH+1  registered result.
- out_valid  out  1  one-cycle pulse qualifying `d_out`. There is no output backpressure.
- err_flag  out  1  pulses with `out_valid` on a probe whose error exceeds ERR_THRESH.
- err_cnt  out  16  count of `err_flag` events; saturates at 0xFFFF.
- mode  out  2  current state: 0 = ACC_RUN, 1 = APX_RUN, 2 = PROBE.

## Operation
- **Operand stage.** Registers `a`, `b`, `acc__sel` and an internal valid bit. The stage loads on every accepted handshake; otherwise its valid bit clears and `a`/`b` hold their values.
- **ACC_RUN.**
  - Each accepted op is loaded with `acc__sel` = 1, and `hold_cnt` decrements.
  - An accepted op with `hold_cnt` = 1 moves the block to APX_RUN and sets `probe_cnt` = 0.
  - While `force_acc` = 1, the block stays in ACC_RUN and `hold_cnt` does not decrement.
- **APX_RUN.**
  - Each accepted op is loaded with `acc__sel` = 0, and `probe_cnt` increments.
  - An accepted op with `probe_cnt` = PROBE_PERIOD-1 is tagged as a probe and the block moves to PROBE.
  - Asserting `force_acc` moves the block to ACC_RUN with `hold_cnt` = ACC_HOLD. This happens on the next edge; an in-flight probe completes first.
- **PROBE.** Takes two cycles on the same operands.
  - Cycle 1 (`acc__sel` = 0): `d` is captured into `apx_hold`. `out_valid` stays low and `in_ready` is 0.
  - Cycle 2: `acc__sel` is set to 1 and `in_ready` returns to 1.
  - Next edge: `d_out` ← `d` (the accurate result) and `out_valid` = 1.
  - `err` = |d − apx_hold|, computed as unsigned on 25 bits.
  - If `err` > ERR_THRESH: `err_flag` = 1, `err_cnt` increments, and the state moves to ACC_RUN with `hold_cnt` = ACC_HOLD.
  - Otherwise the state moves to APX_RUN with `probe_cnt` = 0.
  - `err` = ERR_THRESH exactly does not trigger fallback.
- **Non-probe ops.** `d_out` ← `d` and `out_valid` = 1 one edge after the stage loads.
- **`in_ready`.** Equals 0 only in PROBE cycle 1; it is 1 in every other cycle, including the cycle after reset.
- **Reset values.**
  - `a` = `b` = 0, `acc__sel` = 1.
  - `d_out` = 0, `out_valid` = 0, `err_flag` = 0, `err_cnt` = 0.
  - State = ACC_RUN, `hold_cnt` = ACC_HOLD, `probe_cnt` = 0, `mode` = 0.
- **Reset mid-probe** discards the probe and produces no `out_valid`.

## Timing
- **Normal op.** Accepted at edge k; the adder ports are driven after k; `d_out`/`out_valid` are valid after edge k+1. Latency is 2 edges.
- **Probe op.** Accepted at edge k; `apx_hold` is captured at k+1; `d_out`/`out_valid`/`err_flag` are valid after edge k+2.
- **Throughput.** One op per cycle, except one bubble per probe.
- **Mode transitions.** A mode change triggered by a probe applies to ops accepted at edge k+2 and later. An op accepted at k+2 uses the new mode's `acc__sel`.
- **Combinational path.** `d` is combinational from `a`/`b`/`acc__sel`; the controller registers nothing between the adder ports and the `d` capture.

## Test plan
The bench adder model uses approximate result = {a[23:8]+b[23:8], 8'b0} and accurate result = a+b. Tests use PROBE_PERIOD = 4, ACC_HOLD = 2, ERR_THRESH = 256.

- **Reset exit.** Release reset, then stream 0x000001+0x000002 for 2 ops → `acc__sel` = 1, `d_out` = 0x000003 two edges after each accept, then `mode` = 1.
- **Probe below threshold.** Stream 0x000100+0x000100 in APX_RUN → 4th op is a probe, `in_ready` low exactly 1 cycle, `d_out` = 0x000200, err = 0, no `err_flag`, `mode` returns to 1.
- **Probe above threshold.** Probe with 0x0000FF+0x0000FF → `d_out` = 0x0001FE, err = 510, `err_flag` pulse, `err_cnt` = 1, next 2 ops use `acc__sel` = 1.
- **Threshold boundary.** Probe with 0x000080+0x000080 → err = 256 = ERR_THRESH, no fallback.
- **Forced accurate mode.** Hold `force_acc` = 1 for 10 ops → all use `acc__sel` = 1, no probes; release → `mode` returns to 1 after 2 ops.
- **Reset mid-probe.** Assert `rst` during PROBE cycle 1 → all outputs take their reset values immediately, with no `out_valid`.

Source files
------------

// File: rtl/conf_int_add__acc_sel_ctrl_if.sv
// Bundle between the precision controller and its surroundings: the operand stream,
// the adder port set (a/b/acc__sel out, d back) and the result/status outputs.
interface conf_int_add__acc_sel_ctrl_if #(
    parameter int DATA_PATH_BITWIDTH = 24
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_PATH_BITWIDTH-1:0] a_in;
    logic [DATA_PATH_BITWIDTH-1:0] b_in;
    logic                          force_acc;
    logic [DATA_PATH_BITWIDTH-1:0] a;
    logic [DATA_PATH_BITWIDTH-1:0] b;
    logic                          acc__sel;
    logic [DATA_PATH_BITWIDTH:0]   d;
    logic [DATA_PATH_BITWIDTH:0]   d_out;
    logic                          out_valid;
    logic                          err_flag;
    logic [15:0]                   err_cnt;
    logic [1:0]                    mode;

    // Controller side.
    modport slave (
        input  in_valid, a_in, b_in, force_acc, d,
        output in_ready, a, b, acc__sel, d_out, out_valid, err_flag, err_cnt, mode
    );

    // Environment side: operand source, adder and result sink.
    modport master (
        output in_valid, a_in, b_in, force_acc, d,
        input  in_ready, a, b, acc__sel, d_out, out_valid, err_flag, err_cnt, mode
    );
endinterface

// File: rtl/conf_int_add__acc_sel_ctrl.sv
// Precision controller for the configurable integer adder: registers operands and the
// accurate/approximate select, probes approximation error periodically and falls back.
module conf_int_add__acc_sel_ctrl #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int PROBE_PERIOD       = 64,
    parameter int ERR_THRESH         = 256,
    parameter int ACC_HOLD           = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    conf_int_add__acc_sel_ctrl_if.slave  bus
);
    localparam int         W      = DATA_PATH_BITWIDTH;
    localparam int         PW     = $clog2(PROBE_PERIOD);
    localparam int         HW     = $clog2(ACC_HOLD + 1);
    localparam logic [W:0] THRESH = (W+1)'(ERR_THRESH);

    // PROBE is split into its approximate and accurate cycles; both report mode 2.
    typedef enum logic [1:0] {
        ST_ACC_RUN   = 2'd0,
        ST_APX_RUN   = 2'd1,
        ST_PROBE_APX = 2'd2,
        ST_PROBE_ACC = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt, w_eff_state;
    logic [HW-1:0] r_hold_cnt, w_hold_nxt, w_eff_hold;
    logic [PW-1:0] r_probe_cnt, w_probe_nxt, w_eff_probe;

    logic [W-1:0]  r_a, r_b;
    logic          r_sel, r_vld;
    logic [W:0]    r_apx_hold, r_d_out;
    logic          r_out_valid, r_err_flag;
    logic [15:0]   r_err_cnt;

    logic          w_in_ready, w_accept, w_sel_nxt, w_err_hi;
    logic [W:0]    w_err;

    assign w_in_ready = (r_state != ST_PROBE_APX);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_err      = (bus.d >= r_apx_hold) ? (bus.d - r_apx_hold) : (r_apx_hold - bus.d);
    assign w_err_hi   = (w_err > THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC_RUN;
            r_hold_cnt  <= HW'(ACC_HOLD);
            r_probe_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_probe_cnt <= w_probe_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path can
        // leave a value unassigned and infer a latch.
        w_eff_state = r_state;
        w_eff_hold  = r_hold_cnt;
        w_eff_probe = r_probe_cnt;
        w_sel_nxt   = 1'b1;

        // Resolve the mode that applies to an op accepted on this edge.
        case (r_state)
            ST_APX_RUN: begin
                if (bus.force_acc) begin
                    w_eff_state = ST_ACC_RUN;
                    w_eff_hold  = HW'(ACC_HOLD);
                end
            end
            ST_PROBE_ACC: begin
                if (w_err_hi || bus.force_acc) begin
                    w_eff_state = ST_ACC_RUN;
                    w_eff_hold  = HW'(ACC_HOLD);
                end else begin
                    w_eff_state = ST_APX_RUN;
                    w_eff_probe = '0;
                end
            end
            default: ;
        endcase

        w_state_nxt = w_eff_state;
        w_hold_nxt  = w_eff_hold;
        w_probe_nxt = w_eff_probe;

        if (r_state == ST_PROBE_APX) begin
            w_state_nxt = ST_PROBE_ACC;
        end else if (w_accept) begin
            if (w_eff_state == ST_ACC_RUN) begin
                w_sel_nxt = 1'b1;
                if (!bus.force_acc) begin
                    if (w_eff_hold == HW'(1)) begin
                        w_state_nxt = ST_APX_RUN;
                        w_probe_nxt = '0;
                    end else begin
                        w_hold_nxt = w_eff_hold - HW'(1);
                    end
                end
            end else begin
                w_sel_nxt = 1'b0;
                if (w_eff_probe == PW'(PROBE_PERIOD - 1)) begin
                    w_state_nxt = ST_PROBE_APX;
                end else begin
                    w_probe_nxt = w_eff_probe + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= 1'b1;
            r_vld       <= 1'b0;
            r_apx_hold  <= '0;
            r_d_out     <= '0;
            r_out_valid <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_flag <= 1'b0;
            if (r_state == ST_PROBE_APX) begin
                // Keep the probe operands and valid bit; rerun them in accurate mode.
                r_apx_hold  <= bus.d;
                r_sel       <= 1'b1;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_vld;
                if (r_vld) r_d_out <= bus.d;
                if (r_state == ST_PROBE_ACC) begin
                    r_err_flag <= w_err_hi;
                    if (w_err_hi && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
                end
                r_vld <= w_accept;
                if (w_accept) begin
                    r_a   <= bus.a_in;
                    r_b   <= bus.b_in;
                    r_sel <= w_sel_nxt;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.acc__sel  = r_sel;
    assign bus.d_out     = r_d_out;
    assign bus.out_valid = r_out_valid;
    assign bus.err_flag  = r_err_flag;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.mode      = (r_state == ST_PROBE_ACC) ? 2'd2 : 2'(r_state);
endmodule

// File: tb/tb_conf_int_add__acc_sel_ctrl.sv
// Bench for the adder precision controller: an adder model closes the loop, and a
// transaction-level model predicts select, mode, results and error events per op.
module tb_conf_int_add__acc_sel_ctrl;
    localparam int W   = 24;
    localparam int PP  = 4;
    localparam int AH  = 2;
    localparam int THR = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conf_int_add__acc_sel_ctrl_if #(.DATA_PATH_BITWIDTH(W)) ifc ();

    conf_int_add__acc_sel_ctrl #(
        .DATA_PATH_BITWIDTH(W),
        .PROBE_PERIOD(PP),
        .ERR_THRESH(THR),
        .ACC_HOLD(AH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    function automatic logic [W:0] apx_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        return {17'(x[23:8]) + 17'(y[23:8]), 8'h00};
    endfunction

    function automatic logic [W:0] acc_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        return (W+1)'(x) + (W+1)'(y);
    endfunction

    assign ifc.d = ifc.acc__sel ? acc_sum(ifc.a, ifc.b) : apx_sum(ifc.a, ifc.b);

    typedef struct {
        logic [W:0] d;
        bit         flag;
        int         cnt;
        int         cyc;
        bit         probe;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           f;
        bit           sel;
        logic [1:0]   mode;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[30];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit m_acc;
    int m_hold, m_cnt, m_errs;
    bit bubble_pending;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc  = 1'b1;
        m_hold = AH;
        m_cnt  = 0;
        m_errs = 0;
        bubble_pending = 1'b0;
        exp_q.delete();
    endtask

    // Result monitor: every out_valid must match the oldest predicted op, in order.
    always @(negedge clk) begin
        if (!rst && ifc.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(ifc.out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("d_out", 32'(ifc.d_out), 32'(mon_e.d));
                check("err_flag", 32'(ifc.err_flag), 32'(mon_e.flag));
                check("err_cnt", 32'(ifc.err_cnt), 32'(mon_e.cnt));
                check("latency", 32'(cyc - mon_e.cyc), mon_e.probe ? 32'd2 : 32'd1);
            end
        end
    end

    // Offer one op, predict its treatment, and check the loaded adder ports afterwards.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit f);
        int         waits;
        int         err;
        bit         sel;
        bit         probe;
        logic [W:0] acc_v, apx_v;
        exp_t       e;
        waits = 0;
        err   = 0;
        probe = 1'b0;
        ifc.a_in      = av;
        ifc.b_in      = bv;
        ifc.force_acc = f;
        ifc.in_valid  = 1'b1;
        while (!ifc.in_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        check("in_ready_wait", 32'(waits), bubble_pending ? 32'd1 : 32'd0);
        if (!ifc.in_ready) begin
            $display("FAIL in_ready_stuck: got 0, expected 1");
            $fatal(1, "in_ready never returned");
        end

        acc_v = acc_sum(av, bv);
        apx_v = apx_sum(av, bv);
        if (f && !m_acc) begin
            m_acc  = 1'b1;
            m_hold = AH;
        end
        if (m_acc) begin
            sel = 1'b1;
            if (!f) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_acc = 1'b0;
                    m_cnt = 0;
                end
            end
        end else begin
            sel = 1'b0;
            m_cnt++;
            if (m_cnt == PP) begin
                probe = 1'b1;
                err   = int'(acc_v - apx_v);
                m_cnt = 0;
                if (err > THR) begin
                    m_acc  = 1'b1;
                    m_hold = AH;
                    m_errs++;
                end
            end
        end
        e.d     = (sel || probe) ? acc_v : apx_v;
        e.flag  = probe && (err > THR);
        e.cnt   = m_errs;
        e.cyc   = cyc + 1;
        e.probe = probe;
        exp_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        ifc.in_valid   = 1'b0;
        bubble_pending = probe;
        check("acc__sel", 32'(ifc.acc__sel), 32'(sel));
        check("a", 32'(ifc.a), 32'(av));
        check("b", 32'(ifc.b), 32'(bv));
        check("mode", 32'(ifc.mode), probe ? 32'd2 : (m_acc ? 32'd0 : 32'd1));
        check("in_ready_after", 32'(ifc.in_ready), probe ? 32'd0 : 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bubble_pending = 1'b0;
        end
    endtask

    task automatic setv(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit f, input bit sel, input logic [1:0] mode);
        vecs[i] = '{a, b, f, sel, mode};
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a"}, 32'(ifc.a), 32'd0);
        check({tag, "_b"}, 32'(ifc.b), 32'd0);
        check({tag, "_acc__sel"}, 32'(ifc.acc__sel), 32'd1);
        check({tag, "_d_out"}, 32'(ifc.d_out), 32'd0);
        check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
        check({tag, "_err_flag"}, 32'(ifc.err_flag), 32'd0);
        check({tag, "_err_cnt"}, 32'(ifc.err_cnt), 32'd0);
        check({tag, "_mode"}, 32'(ifc.mode), 32'd0);
        check({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit f;
        ifc.in_valid  = 1'b0;
        ifc.a_in      = '0;
        ifc.b_in      = '0;
        ifc.force_acc = 1'b0;
        model_reset();

        // Directed table: reset exit, probes below/above/at threshold, forced mode.
        setv(0, 24'h000001, 24'h000002, 1'b0, 1'b1, 2'd0);
        setv(1, 24'h000001, 24'h000002, 1'b0, 1'b1, 2'd1);
        for (int i = 2; i < 5; i++) setv(i, 24'h000100, 24'h000100, 1'b0, 1'b0, 2'd1);
        setv(5, 24'h000100, 24'h000100, 1'b0, 1'b0, 2'd2);
        for (int i = 6; i < 9; i++) setv(i, 24'h0000FF, 24'h0000FF, 1'b0, 1'b0, 2'd1);
        setv(9, 24'h0000FF, 24'h0000FF, 1'b0, 1'b0, 2'd2);
        setv(10, 24'h000001, 24'h000002, 1'b0, 1'b1, 2'd0);
        setv(11, 24'h000001, 24'h000002, 1'b0, 1'b1, 2'd1);
        for (int i = 12; i < 15; i++) setv(i, 24'h000080, 24'h000080, 1'b0, 1'b0, 2'd1);
        setv(15, 24'h000080, 24'h000080, 1'b0, 1'b0, 2'd2);
        setv(16, 24'h000005, 24'h000006, 1'b0, 1'b0, 2'd1);
        for (int i = 17; i < 27; i++) setv(i, 24'h123456 + 24'(i), 24'h0F0F0F, 1'b1, 1'b1, 2'd0);
        setv(27, 24'h000007, 24'h000008, 1'b0, 1'b1, 2'd0);
        setv(28, 24'h000007, 24'h000008, 1'b0, 1'b1, 2'd1);
        setv(29, 24'h000007, 24'h000008, 1'b0, 1'b0, 2'd1);

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_post_reset", 32'(ifc.in_ready), 32'd1);

        for (int i = 0; i < 30; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].f);
            check($sformatf("vec%0d_sel", i), 32'(ifc.acc__sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_mode", i), 32'(ifc.mode), 32'(vecs[i].mode));
        end
        idle(3);
        check("table_err_cnt", 32'(ifc.err_cnt), 32'd1);
        check("table_drained", 32'(exp_q.size()), 32'd0);

        // Random stream with idle gaps and force_acc runs against the model.
        f = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) f = !f;
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
            send(24'($urandom), 24'($urandom), f);
        end
        idle(4);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Reset while the probe's approximate cycle is in flight.
        send(24'h000001, 24'h000002, 1'b1);
        for (int k = 0; k < 3 && ifc.mode != 2'd1; k++) send(24'h000001, 24'h000002, 1'b0);
        repeat (4) send(24'h000100, 24'h000100, 1'b0);
        check("midprobe_mode", 32'(ifc.mode), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midprobe_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midprobe_no_out_valid", 32'(ifc.out_valid), 32'd0);
        end
        check("midprobe_mode_after", 32'(ifc.mode), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
